// File: rtl/enum_t.sv
// rtl/enum_t.sv - shared enums and constants for the I2C engine arbiter
// Engine command/status encodings, arbiter FSM states and the default watchdog limit.
package enum_t;

  typedef enum logic [1:0] {
    EN_STOP  = 2'd0,
    EN_START = 2'd1,
    EN_WR    = 2'd2,
    EN_RD    = 2'd3
  } en_t;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    START = 2'd1,
    WR    = 2'd2,
    RD    = 2'd3
  } i2c_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } arb_t;

  localparam int DEF_TIMEOUT = 100000;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_arb_if.sv
// rtl/i2c_arb_if.sv - requester/engine bundle shared through the arbiter
// slave is the arbiter side, master is the requester/engine side.
interface i2c_arb_if
  import enum_t::*;
#(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] err;
  logic [7:0]      data_i [NREQ];
  en_t             en_i   [NREQ];
  logic [7:0]      data;
  en_t             en;
  i2c_t            st;

  modport slave (
    input  req, data_i, en_i, st,
    output gnt, err, data, en
  );

  modport master (
    output req, data_i, en_i, st,
    input  gnt, err, data, en
  );

endinterface

// File: rtl/i2c_arb_rr_pick.sv
// rtl/i2c_arb_rr_pick.sv - round-robin priority encoder
// Returns the first set request searching upward from last+1, wrapping at NREQ.
module rr_pick
  import enum_t::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last) + i) % NREQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// rtl/i2c_arb.sv - round-robin arbiter sharing one I2C engine among NREQ clients
// Falling-edge logic to match the engine client side; watchdog aborts stalled sessions.
module i2c_arb
  import enum_t::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic      clk,
  input logic      rst,
  i2c_arb_if.slave bus
);

  localparam int IW = idx_w(NREQ);

  arb_t            state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [31:0]     wd_q, wd_d;
  i2c_t            st_prev_q;

  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            st_chg;
  logic [31:0]     wd_inc;
  logic            wd_expire;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (bus.req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign st_chg    = (bus.st != st_prev_q);
  assign wd_inc    = wd_q + 32'd1;
  assign wd_expire = !st_chg && (wd_inc == 32'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    err_d   = '0;
    wd_d    = '0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          owner_d         = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          state_d         = OWN;
        end
      end
      OWN: begin
        wd_d = st_chg ? 32'd0 : wd_inc;
        if (!bus.req[owner_q]) begin
          gnt_d   = '0;
          state_d = (bus.st == STOP) ? RELEASE : DRAIN;
        end else if (wd_expire) begin
          err_d[owner_q] = 1'b1;
          gnt_d          = '0;
          wd_d           = '0;
          state_d        = DRAIN;
        end
      end
      DRAIN: begin
        // A second watchdog expiry releases even if the engine never reports STOP.
        gnt_d = '0;
        wd_d  = st_chg ? 32'd0 : wd_inc;
        if (bus.st == STOP || wd_expire) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Engine command path is combinational through the registered owner.
  always_comb begin
    bus.data = 8'd0;
    bus.en   = EN_STOP;
    if (state_q == OWN) begin
      bus.data = bus.data_i[owner_q];
      bus.en   = bus.en_i[owner_q];
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.err = err_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IW'(NREQ - 1);
      gnt_q     <= '0;
      err_q     <= '0;
      wd_q      <= '0;
      st_prev_q <= STOP;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      st_prev_q <= bus.st;
    end
  end

endmodule

// File: doc/i2c_arb.md
I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one I2C engine.
REQ-002 Parameter TIMEOUT, default 100000: clk cycles without engine status change before forced abort.
REQ-003 clk  input  1  system clock; all sequential logic updates on its falling edge, matching the I2C engine client side.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req  input  NREQ  per-requester bus request; held high while the requester wants ownership.
REQ-006 gnt  output  NREQ  one-hot-or-zero grant, registered.
REQ-007 data_i  input  NREQ x 8  per-requester byte to the engine.
REQ-008 en_i  input  NREQ x enum_t::en_t  per-requester engine command.
REQ-009 err  output  NREQ  one-cycle pulse to the owner whose session was timed out.
REQ-010 data  output  8  byte to the I2C engine.
REQ-011 en  output  enum_t::en_t  command to the I2C engine.
REQ-012 st  input  enum_t::i2c_t  engine status, forwarded unchanged to requesters, which qualify it with their own gnt bit.

Function
REQ-013 FSM states: IDLE, OWN, DRAIN, RELEASE.
REQ-014 IDLE: if any req bit is high, select the first set bit searching upward from last+1 modulo NREQ, register owner, set gnt[owner], go to OWN; gnt rises one clk after req is sampled.
REQ-015 IDLE, no req: gnt all zero, en = EN_STOP, data = 0.
REQ-016 OWN: data = data_i[owner], en = en_i[owner], combinational through the registered owner index, with zero added latency.
REQ-017 OWN, req[owner] low and st == STOP: go to RELEASE.
REQ-018 OWN, req[owner] low and st != STOP (mid-transfer drop): go to DRAIN.
REQ-019 OWN, watchdog: a 32-bit counter clears on any st change and increments otherwise; when it reaches TIMEOUT, pulse err[owner] for one cycle and go to DRAIN.
REQ-020 DRAIN: en forced to EN_STOP and data = 0 regardless of owner inputs; gnt[owner] low; go to RELEASE on st == STOP; the watchdog keeps running, and on a second expiry the FSM goes to RELEASE anyway.
REQ-021 RELEASE: last <= owner, gnt all zero, en = EN_STOP; IDLE on the next cycle, giving a guaranteed one-cycle gap with no grant between owners.
REQ-022 Requests from non-owners during OWN, DRAIN or RELEASE are ignored, not latched; they must stay high until granted.
REQ-023 A requester rising in the same cycle as RELEASE is considered in the following IDLE cycle.
REQ-024 With all req bits high permanently, grants rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 sessions.
REQ-025 At most one gnt bit is high in any cycle.

Reset
REQ-026 On rst: state IDLE, gnt 0, err 0, owner 0, last NREQ-1 (requester 0 has first priority), watchdog 0, en EN_STOP, data 0.
REQ-027 rst asserted mid-session drops the grant immediately; the engine sees EN_STOP from the next edge, and no err is produced.

Structure
REQ-028 The arbiter FSM enum arb_t and the default TIMEOUT constant belong in the shared enum_t package, alongside en_t and i2c_t.
REQ-029 One sub-module, rr_pick: combinational round-robin priority encoder (inputs req and last, outputs index and valid).
REQ-030 No other sub-modules; the data/en mux and watchdog reside in i2c_arb.

Verification
REQ-031 After reset, req=2'b01 -> gnt=2'b01 one clk later; en/data follow requester 0; req0 low with st=STOP -> gnt=0 for exactly one cycle, then IDLE.
REQ-032 req=2'b11 held for 4 sessions, each owner dropping req after STOP -> grant order 0,1,0,1; never both bits set.
REQ-033 Owner 1 drops req while st=WR -> en=EN_STOP next cycle; gnt remains 0 until st=STOP, then RELEASE; err stays 0.
REQ-034 TIMEOUT=50, owner 0 granted, st frozen at WR -> err[0] pulses on cycle 50 after the last st change; en=EN_STOP; requester 1 is granted after STOP plus the one-cycle gap.
REQ-035 rst pulsed during OWN with en_i[0]=EN_RD -> next cycle gnt=0, en=EN_STOP, data=0; requester 0 is granted first afterward when req=2'b11.
REQ-036 req1 rises in the RELEASE cycle of owner 0 -> gnt=2'b10 two clks later.
